memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
Backing-store side of the cache/memory interface. Serves two cache ports. Each port sends a 25-bit request (1-bit cmd, 8-bit data, 16-bit address) with a ready level and receives a 16-bit block response with a one-cycle ready pulse. A round-robin arbiter serializes the two ports onto one word-organised memory. On a write from one port, the controller drives that address on the other port's invalidate_address output to keep the caches coherent.

Parameters:
WORD_ADDR_BITS, 8, number of word-index bits used from address[WORD_ADDR_BITS:1]; memory depth is 2**WORD_ADDR_BITS 16-bit words
MEM_LATENCY, 4, cycles spent in ACCESS per request; must be >= 2

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low
memory_request_0  input  25  port 0 request: [24] cmd (0 read, 1 write), [23:16] data, [15:0] address
memory_request_ready_0  input  1  port 0 request valid; level, held until response seen
memory_response_0  output  16  port 0 block data
memory_response_ready_0  output  1  port 0 response strobe, one-cycle pulse
invalidate_address_0  output  16  address port 0's cache must invalidate; acts on value change
memory_request_1, memory_request_ready_1, memory_response_1, memory_response_ready_1, invalidate_address_1: identical to the port 0 signals, for port 1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - all outputs go to 0; state goes to IDLE; last_grant=1, so port 0 wins the first tie.
  - both armed flags go to 1; all memory words are cleared to 16'h0000.
- Addressing:
  - word index = address[WORD_ADDR_BITS:1]; higher address bits are ignored, so addresses alias.
  - address[0] selects the byte: 0 is [7:0], 1 is [15:8].
- Armed flag per port:
  - cleared when that port's response pulses.
  - set again on any cycle that port's request_ready is sampled low.
  - a port is eligible only when request_ready=1 and its armed flag is set. This prevents double-serving a request the cache is still holding.
- IDLE:
  - if both ports are eligible, grant the port != last_grant; if one is eligible, grant it.
  - on the grant edge, latch the request and grant id, update last_grant, go to ACCESS with count=0.
  - with no eligible port, stay in IDLE.
- ACCESS:
  - count increments every cycle; after MEM_LATENCY cycles, go to RESPOND.
  - for a write, the other port's invalidate_address is driven to ~address in ACCESS cycle 1 and to address in cycle 2, then held.
  - the two-step forces a value change even when the same address is written twice. A spurious invalidation from ~address is coherence-safe.
  - the writing port's own invalidate_address is unchanged.
- RESPOND, one cycle:
  - read: memory_response_g = mem[index].
  - write: merged word = mem[index] with the addressed byte replaced by data. The merged word is written to the memory and also driven as memory_response_g. The cache stores the whole response block, so it must be the post-write value.
  - memory_response_ready_g=1 for this cycle only; clear armed_g; return to IDLE.
  - memory_response_g holds its value until the next response to that port.
- Latency: memory_response_ready rises MEM_LATENCY+1 rising edges after the grant edge. A new grant is possible on the edge following RESPOND.
- The ungranted port's request is ignored until arbitration; no queueing.
- Reset mid-operation: the transaction is aborted; memory is cleared by reset, so no partial commit is visible. No response is issued for the aborted request.
- The request inputs are sampled only at the grant edge; later changes are ignored until the next grant.

Test Plan:
- Reset, then port0 read 0x0010 -> memory_response_0=16'h0000 with ready_0 high for exactly one cycle, 5 edges after the grant edge.
- Port0 write {1,8'hAB,16'h0021} -> response_0=16'hAB00; invalidate_address_1 goes 16'hFFDE then 16'h0021; invalidate_address_0 stays 0. Then port1 read 0x0020 -> 16'hAB00.
- Port0 writes 8'h5A to 0x0020 after the previous test -> response 16'hAB5A; a second identical write still produces the 16'hFFDF/16'h0020 sequence on invalidate_address_1.
- Both ports assert ready on the same cycle after reset -> port0 is served first, port1 on the next grant; repeat the tie -> port0 wins again (last_grant=1).
- Port0 holds ready high for 10 cycles after its response -> no second response_ready_0 until ready_0 is dropped for at least one cycle and then re-asserted.
- Write to 0x0040 with reset pulsed during ACCESS cycle 2 -> all outputs 0, busy=0; a subsequent read of 0x0040 returns 16'h0000.

Source files
------------

// File: rtl/memory_controller.sv
// Backing store for two cache ports. Round-robin arbitration onto one word-organised
// memory, fixed access latency, and cross-port invalidation on writes.
module memory_controller #(
  parameter int WORD_ADDR_BITS = 8,
  parameter int MEM_LATENCY    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] memory_request_0,
  input  logic        memory_request_ready_0,
  output logic [15:0] memory_response_0,
  output logic        memory_response_ready_0,
  output logic [15:0] invalidate_address_0,
  input  logic [24:0] memory_request_1,
  input  logic        memory_request_ready_1,
  output logic [15:0] memory_response_1,
  output logic        memory_response_ready_1,
  output logic [15:0] invalidate_address_1,
  output logic        busy
);

  localparam int DEPTH = 2 ** WORD_ADDR_BITS;
  localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                    state, state_next;
  logic [CNT_W-1:0]          count;
  logic                      last_grant, grant_id, grant_sel;
  logic [1:0]                armed, eligible, ready_in;
  logic [24:0]               req_q;
  logic [15:0]               mem [DEPTH];

  logic                      req_write;
  logic [7:0]                req_data;
  logic [15:0]               req_addr;
  logic [WORD_ADDR_BITS-1:0] word_index;
  logic [15:0]               stored_word, merged_word, response_word;
  logic                      last_access;

  assign req_write     = req_q[24];
  assign req_data      = req_q[23:16];
  assign req_addr      = req_q[15:0];
  assign word_index    = req_addr[WORD_ADDR_BITS:1];
  assign stored_word   = mem[word_index];
  assign merged_word   = req_addr[0] ? {req_data, stored_word[7:0]}
                                     : {stored_word[15:8], req_data};
  assign response_word = req_write ? merged_word : stored_word;
  assign last_access   = (count == CNT_W'(MEM_LATENCY - 1));

  // A port is only considered once it has dropped ready since its last response.
  assign ready_in  = {memory_request_ready_1, memory_request_ready_0};
  assign eligible  = ready_in & armed;
  assign grant_sel = (&eligible) ? ~last_grant : eligible[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|eligible)  state_next = ACCESS;
      ACCESS:  if (last_access) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      req_q      <= '0;
      armed      <= 2'b11;
    end else begin
      if (state == IDLE && |eligible) begin
        grant_id   <= grant_sel;
        last_grant <= grant_sel;
        req_q      <= grant_sel ? memory_request_1 : memory_request_0;
        count      <= '0;
      end else if (state == ACCESS) begin
        count <= count + CNT_W'(1);
      end

      if (state == RESPOND && !grant_id)     armed[0] <= 1'b0;
      else if (!memory_request_ready_0)      armed[0] <= 1'b1;
      if (state == RESPOND && grant_id)      armed[1] <= 1'b0;
      else if (!memory_request_ready_1)      armed[1] <= 1'b1;
    end
  end

  // Write invalidation is a two-step ~addr then addr so the other cache always sees a change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memory_response_0       <= '0;
      memory_response_1       <= '0;
      memory_response_ready_0 <= 1'b0;
      memory_response_ready_1 <= 1'b0;
      invalidate_address_0    <= '0;
      invalidate_address_1    <= '0;
    end else begin
      memory_response_ready_0 <= 1'b0;
      memory_response_ready_1 <= 1'b0;
      if (state == ACCESS && req_write && count == CNT_W'(0)) begin
        if (grant_id) invalidate_address_0 <= ~req_addr;
        else          invalidate_address_1 <= ~req_addr;
      end
      if (state == ACCESS && req_write && count == CNT_W'(1)) begin
        if (grant_id) invalidate_address_0 <= req_addr;
        else          invalidate_address_1 <= req_addr;
      end
      if (state == RESPOND) begin
        if (grant_id) begin
          memory_response_1       <= response_word;
          memory_response_ready_1 <= 1'b1;
        end else begin
          memory_response_0       <= response_word;
          memory_response_ready_0 <= 1'b1;
        end
      end
    end
  end

  // NOTE: the memory is cleared on reset so an aborted write never leaves a partial commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == RESPOND && req_write) begin
      mem[word_index] <= merged_word;
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench: transaction-level model of the two-port memory controller,
// compared every cycle, plus directed cases with hand-computed expectations.
module tb_memory_controller;

  localparam int MEM_LATENCY = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] req0 = '0, req1 = '0;
  logic        rdy0 = 1'b0, rdy1 = 1'b0;
  logic [15:0] resp0, resp1, inv0, inv1;
  logic        rr0, rr1, busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  memory_controller #(.WORD_ADDR_BITS(8), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .memory_request_0       (req0),
    .memory_request_ready_0 (rdy0),
    .memory_response_0      (resp0),
    .memory_response_ready_0(rr0),
    .invalidate_address_0   (inv0),
    .memory_request_1       (req1),
    .memory_request_ready_1 (rdy1),
    .memory_response_1      (resp1),
    .memory_response_ready_1(rr1),
    .invalidate_address_1   (inv1),
    .busy                   (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [15:0] m_mem [256];
  bit          m_armed [2];
  bit          m_last;
  bit          m_active;
  int          m_age;
  int          m_port;
  logic [24:0] m_req;
  logic [15:0] e_resp [2];
  logic [15:0] e_inv  [2];
  bit          e_rr   [2];

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      m_armed[p] = 1'b1; e_resp[p] = '0; e_inv[p] = '0; e_rr[p] = 1'b0;
    end
    m_last = 1'b1; m_active = 1'b0; m_age = 0; m_port = 0; m_req = '0;
  endfunction

  always @(posedge clock or negedge reset) begin
    logic [15:0] addr, word;
    bit          rdy [2];
    bit          elig [2];
    int          done_port;
    if (!reset) begin
      model_clear();
    end else begin
      done_port = -1;
      rdy[0] = rdy0; rdy[1] = rdy1;
      e_rr[0] = 1'b0; e_rr[1] = 1'b0;
      if (m_active) begin
        m_age++;
        addr = m_req[15:0];
        if (m_req[24] && m_age == 1) e_inv[1 - m_port] = ~addr;
        if (m_req[24] && m_age == 2) e_inv[1 - m_port] = addr;
        if (m_age == MEM_LATENCY + 1) begin
          word = m_mem[addr[8:1]];
          if (m_req[24]) begin
            if (addr[0]) word[15:8] = m_req[23:16];
            else         word[7:0]  = m_req[23:16];
            m_mem[addr[8:1]] = word;
          end
          e_resp[m_port] = word;
          e_rr[m_port]   = 1'b1;
          done_port      = m_port;
          m_active       = 1'b0;
        end
      end else begin
        elig[0] = rdy[0] && m_armed[0];
        elig[1] = rdy[1] && m_armed[1];
        if (elig[0] || elig[1]) begin
          if (elig[0] && elig[1]) m_port = m_last ? 0 : 1;
          else                    m_port = elig[1] ? 1 : 0;
          m_last   = (m_port == 1);
          m_req    = (m_port == 1) ? req1 : req0;
          m_active = 1'b1;
          m_age    = 0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (done_port == p) m_armed[p] = 1'b0;
        else if (!rdy[p])   m_armed[p] = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en && reset === 1'b1) begin
      check("busy",  {31'b0, busy}, {31'b0, m_active});
      check("rr0",   {31'b0, rr0},  {31'b0, e_rr[0]});
      check("rr1",   {31'b0, rr1},  {31'b0, e_rr[1]});
      check("resp0", {16'b0, resp0}, {16'b0, e_resp[0]});
      check("resp1", {16'b0, resp1}, {16'b0, e_resp[1]});
      check("inv0",  {16'b0, inv0},  {16'b0, e_inv[0]});
      check("inv1",  {16'b0, inv1},  {16'b0, e_inv[1]});
    end
  end

  // ---------------- port driver ----------------
  function automatic logic get_rr(input int p);
    return (p == 0) ? rr0 : rr1;
  endfunction
  function automatic logic [15:0] get_resp(input int p);
    return (p == 0) ? resp0 : resp1;
  endfunction
  function automatic logic [15:0] get_inv(input int p);
    return (p == 0) ? inv0 : inv1;
  endfunction

  task automatic port_txn(input int p, input logic [24:0] req, input int hold,
                          output logic [15:0] resp, output int lat,
                          output logic [15:0] inv_a, output logic [15:0] inv_b,
                          output int extra);
    bit got;
    got = 1'b0; lat = 0; extra = 0; resp = 'x; inv_a = 'x; inv_b = 'x;
    @(negedge clock);
    if (p == 0) begin req0 = req; rdy0 = 1'b1; end
    else        begin req1 = req; rdy1 = 1'b1; end
    while (!got && lat < 200) begin
      @(negedge clock);
      lat++;
      if (lat == 2) inv_a = get_inv(1 - p);
      if (lat == 3) inv_b = get_inv(1 - p);
      if (get_rr(p)) begin got = 1'b1; resp = get_resp(p); end
    end
    if (!got) check($sformatf("timeout_p%0d", p), 32'(got), 32'd1);
    repeat (hold) begin
      @(negedge clock);
      if (get_rr(p)) extra++;
    end
    if (p == 0) rdy0 = 1'b0;
    else        rdy1 = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rr",   {30'b0, rr1, rr0}, 32'd0);
    check("rst_resp", {resp1, resp0}, 32'd0);
    check("rst_inv",  {inv1, inv0}, 32'd0);
    @(negedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic agent(input int p, input int n);
    logic [15:0] r, ia, ib, addr;
    int lat, extra;
    for (int i = 0; i < n; i++) begin
      addr = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) addr = addr | 16'hA000;
      port_txn(p, {1'($urandom_range(0, 1)), 8'($urandom), addr},
               $urandom_range(0, 3), r, lat, ia, ib, extra);
      check("rand_hold", 32'(extra), 32'd0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  initial begin
    logic [15:0] r, ia, ib, r1, ia1, ib1;
    int lat, lat1, extra, extra1;

    #1 reset = 1'b0;
    #1;
    check("init_busy", {31'b0, busy}, 32'd0);
    check("init_out",  {resp1, resp0}, 32'd0);
    @(negedge clock);
    #1 reset = 1'b1;
    cmp_en = 1'b1;

    // read after reset: zero, latency and single-cycle strobe
    port_txn(0, {1'b0, 8'h00, 16'h0010}, 1, r, lat, ia, ib, extra);
    check("rd0_data", 32'(r), 32'h0000);
    check("rd0_lat",  32'(lat), 32'd6);
    check("rd0_pulse", 32'(extra), 32'd0);

    // high-byte write and cross-port invalidation
    port_txn(0, {1'b1, 8'hAB, 16'h0021}, 0, r, lat, ia, ib, extra);
    check("wr_ab_data", 32'(r), 32'hAB00);
    check("wr_ab_inva", 32'(ia), 32'hFFDE);
    check("wr_ab_invb", 32'(ib), 32'h0021);
    check("wr_ab_inv0", 32'(inv0), 32'h0000);
    port_txn(1, {1'b0, 8'h00, 16'h0020}, 0, r, lat, ia, ib, extra);
    check("rd1_data", 32'(r), 32'hAB00);

    // low-byte merge, then an identical write still toggles invalidation
    for (int k = 0; k < 2; k++) begin
      port_txn(0, {1'b1, 8'h5A, 16'h0020}, 0, r, lat, ia, ib, extra);
      check($sformatf("wr_5a_data%0d", k), 32'(r), 32'hAB5A);
      check($sformatf("wr_5a_inva%0d", k), 32'(ia), 32'hFFDF);
      check($sformatf("wr_5a_invb%0d", k), 32'(ib), 32'h0020);
    end

    // simultaneous requests after reset: port 0 wins both ties
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      fork
        port_txn(0, {1'b0, 8'h00, 16'h0002}, 0, r, lat, ia, ib, extra);
        port_txn(1, {1'b0, 8'h00, 16'h0004}, 0, r1, lat1, ia1, ib1, extra1);
      join
      check($sformatf("tie%0d_lat0", k), 32'(lat), 32'd6);
      check($sformatf("tie%0d_lat1", k), 32'(lat1), 32'd12);
    end

    // held ready is not served twice; re-arming needs a low cycle
    port_txn(0, {1'b0, 8'h00, 16'h0006}, 10, r, lat, ia, ib, extra);
    check("hold_extra", 32'(extra), 32'd0);
    port_txn(0, {1'b0, 8'h00, 16'h0006}, 0, r, lat, ia, ib, extra);
    check("rearm_lat", 32'(lat), 32'd6);

    // reset during a write's ACCESS phase aborts it
    @(negedge clock);
    req0 = {1'b1, 8'h77, 16'h0040};
    rdy0 = 1'b1;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_out",  {30'b0, rr1, rr0}, 32'd0);
    check("abort_inv",  {inv1, inv0}, 32'd0);
    rdy0 = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    port_txn(0, {1'b0, 8'h00, 16'h0040}, 0, r, lat, ia, ib, extra);
    check("abort_rd", 32'(r), 32'h0000);

    // randomized concurrent traffic against the model
    fork
      agent(0, 40);
      agent(1, 40);
    join
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
